// File: rtl/mpadder_cs_pipe.sv
// Two-stage carry-select adder/subtractor for wide unsigned operands.
// Stage 1 forms per-block candidate sums; stage 2 ripples the block carries to select them.
module mpadder_cs_pipe #(
    parameter int WIDTH  = 1026,
    parameter int BLK    = 128,
    parameter int PRED_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              subtract,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    output logic              busy,
    output logic              done,
    output logic [WIDTH:0]    result,
    output logic [PRED_W-1:0] prediction
);

    localparam int WE = WIDTH + 1;
    localparam int NB = (WIDTH + BLK - 1) / BLK;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STAGE1 = 2'd1,
        STAGE2 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load_op_s, load_s1_s;
    logic [WE-1:0]     a_q, b_q;
    logic              cin_q;
    logic [WE-1:0]     sum0_q, sum1_q;
    logic [NB-2:0]     cy0_q, cy1_q;
    logic [WE-1:0]     result_q;
    logic [PRED_W-1:0] pred_q;

    logic [WE-1:0]     b_ext_s;
    logic [WE-1:0]     sum0_s, sum1_s;
    logic [NB-2:0]     cy0_s, cy1_s;
    logic [NB-1:0]     blk_cin_s;
    logic [WE-1:0]     result_s;

    // Subtraction adds the bitwise inverse of the zero-extended B with carry-in 1.
    assign b_ext_s = subtract ? ~{1'b0, in_b} : {1'b0, in_b};

    assign blk_cin_s[0] = 1'b0;

    for (genvar gi = 0; gi < NB; gi++) begin : g_blk
        localparam int LO = gi * BLK;
        localparam int BW = (gi == NB - 1) ? (WE - LO) : BLK;

        if (gi == 0) begin : g_first
            // Block 0 is fully resolved in stage 1, so both candidates are the true sum.
            logic [BW:0] add_s;
            assign add_s = {1'b0, a_q[LO +: BW]} + {1'b0, b_q[LO +: BW]} + {{BW{1'b0}}, cin_q};
            assign sum0_s[LO +: BW] = add_s[BW-1:0];
            assign sum1_s[LO +: BW] = add_s[BW-1:0];
            assign cy0_s[gi]        = add_s[BW];
            assign cy1_s[gi]        = add_s[BW];
        end else if (gi == NB - 1) begin : g_top
            // The top block carry leaves the WIDTH+1 result and is dropped.
            assign sum0_s[LO +: BW] = a_q[LO +: BW] + b_q[LO +: BW];
            assign sum1_s[LO +: BW] = a_q[LO +: BW] + b_q[LO +: BW] + BW'(1);
        end else begin : g_mid
            logic [BW:0] add0_s, add1_s;
            assign add0_s = {1'b0, a_q[LO +: BW]} + {1'b0, b_q[LO +: BW]};
            assign add1_s = {1'b0, a_q[LO +: BW]} + {1'b0, b_q[LO +: BW]} + {{BW{1'b0}}, 1'b1};
            assign sum0_s[LO +: BW] = add0_s[BW-1:0];
            assign sum1_s[LO +: BW] = add1_s[BW-1:0];
            assign cy0_s[gi]        = add0_s[BW];
            assign cy1_s[gi]        = add1_s[BW];
        end

        if (gi > 0) begin : g_sel
            assign blk_cin_s[gi] = blk_cin_s[gi-1] ? cy1_q[gi-1] : cy0_q[gi-1];
        end
        assign result_s[LO +: BW] = blk_cin_s[gi] ? sum1_q[LO +: BW] : sum0_q[LO +: BW];
    end

    // Sequencer next state, stage enables and status outputs.
    always_comb begin
        state_d   = state_q;
        load_op_s = 1'b0;
        load_s1_s = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = STAGE1;
                    load_op_s = 1'b1;
                end else begin
                    state_d   = IDLE;
                end
            end
            STAGE1: begin
                state_d   = STAGE2;
                load_s1_s = 1'b1;
            end
            STAGE2: begin
                state_d   = IDLE;
                done_d    = 1'b1;
            end
            default: begin
                state_d   = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Control registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Operand capture and pipeline stage registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            sum0_q   <= '0;
            sum1_q   <= '0;
            cy0_q    <= '0;
            cy1_q    <= '0;
            pred_q   <= '0;
            result_q <= '0;
        end else begin
            if (load_op_s) begin
                a_q   <= {1'b0, in_a};
                b_q   <= b_ext_s;
                cin_q <= subtract;
            end
            if (load_s1_s) begin
                sum0_q <= sum0_s;
                sum1_q <= sum1_s;
                cy0_q  <= cy0_s;
                cy1_q  <= cy1_s;
                pred_q <= sum0_s[PRED_W-1:0];
            end
            if (done_d) begin
                result_q <= result_s;
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign prediction = pred_q;

endmodule

// File: tb/tb_mpadder_cs_pipe.sv
// Scoreboard bench: one stimulus stream drives three adder configurations,
// each checked against plain wide arithmetic.
module tb_mpadder_cs_pipe;

    localparam int W0 = 1026;
    localparam int W1 = 256;
    localparam int W2 = 200;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic          subtract;
    logic [W0-1:0] in_a, in_b;

    logic          busy0, busy1, busy2;
    logic          done0, done1, done2;
    logic [W0:0]   result0;
    logic [W1:0]   result1;
    logic [W2:0]   result2;
    logic [PW-1:0] pred0, pred1, pred2;

    int checks = 0;
    int errors = 0;

    logic [W0:0] q0[$];
    logic [W0:0] q1[$];
    logic [W0:0] q2[$];

    always #5 clk = ~clk;

    mpadder_cs_pipe u_dut0 (
        .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
        .in_a(in_a), .in_b(in_b), .busy(busy0), .done(done0),
        .result(result0), .prediction(pred0)
    );

    mpadder_cs_pipe #(.WIDTH(W1), .BLK(32), .PRED_W(PW)) u_dut1 (
        .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
        .in_a(in_a[W1-1:0]), .in_b(in_b[W1-1:0]), .busy(busy1), .done(done1),
        .result(result1), .prediction(pred1)
    );

    mpadder_cs_pipe #(.WIDTH(W2), .BLK(64), .PRED_W(PW)) u_dut2 (
        .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
        .in_a(in_a[W2-1:0]), .in_b(in_b[W2-1:0]), .busy(busy2), .done(done2),
        .result(result2), .prediction(pred2)
    );

    // Reference: truncate operands to w bits, add or subtract, keep w+1 bits.
    function automatic logic [W0:0] ref_op(input logic [W0-1:0] a, input logic [W0-1:0] b,
                                           input logic sub, input int w);
        logic [W0:0] mask, ae, be, r;
        mask = '0;
        for (int i = 0; i <= w; i++) mask[i] = 1'b1;
        ae = {1'b0, a} & (mask >> 1);
        be = {1'b0, b} & (mask >> 1);
        r  = sub ? (ae - be) : (ae + be);
        return r & mask;
    endfunction

    function automatic logic [W0-1:0] rnd_wide();
        logic [32*33-1:0] t;
        for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom;
        return t[W0-1:0];
    endfunction

    task automatic chk(input string name, input logic [W0:0] act, input logic [W0:0] exp);
        int diff_bit;
        checks++;
        if (act !== exp) begin
            errors++;
            diff_bit = -1;
            for (int i = W0; i >= 0; i--) if (act[i] !== exp[i] && diff_bit < 0) diff_bit = i;
            $display("FAIL %s actual(low256)=%h required(low256)=%h top_bit act=%b req=%b first_diff_bit=%0d",
                     name, act[255:0], exp[255:0], act[W0], exp[W0], diff_bit);
        end
    endtask

    // Monitors: pop the oldest expectation whenever a configuration reports done.
    always @(negedge clk) begin
        logic [W0:0] e;
        if (done0) begin
            if (q0.size() == 0) chk("dut0_spurious_done", 1'b1, 1'b0);
            else begin
                e = q0.pop_front();
                chk("dut0_result", result0, e);
                chk("dut0_pred_at_done", {{(W0+1-PW){1'b0}}, pred0}, {{(W0+1-PW){1'b0}}, e[PW-1:0]});
            end
        end
        if (done1) begin
            if (q1.size() == 0) chk("dut1_spurious_done", 1'b1, 1'b0);
            else begin
                e = q1.pop_front();
                chk("dut1_result", {{(W0-W1){1'b0}}, result1}, e);
            end
        end
        if (done2) begin
            if (q2.size() == 0) chk("dut2_spurious_done", 1'b1, 1'b0);
            else begin
                e = q2.pop_front();
                chk("dut2_result", {{(W0-W2){1'b0}}, result2}, e);
            end
        end
    end

    // One operation: called and returning at a falling edge; returns in the done cycle.
    task automatic issue(input logic [W0-1:0] a, input logic [W0-1:0] b,
                         input logic sub, input bit poke);
        logic [W0:0] e0, e1, e2;
        e0 = ref_op(a, b, sub, W0);
        e1 = ref_op(a, b, sub, W1);
        e2 = ref_op(a, b, sub, W2);
        q0.push_back(e0);
        q1.push_back(e1);
        q2.push_back(e2);
        in_a = a; in_b = b; subtract = sub; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            in_a = ~a; in_b = a; subtract = ~sub; start = 1'b1;
        end
        chk("busy_k", busy0, 1'b1);
        chk("done_k", done0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_k1", busy0, 1'b1);
        chk("done_k1", done0, 1'b0);
        chk("pred0_k1", pred0, e0[PW-1:0]);
        chk("pred1_k1", pred1, e1[PW-1:0]);
        chk("pred2_k1", pred2, e2[PW-1:0]);
        @(posedge clk);
        @(negedge clk);
        chk("done_k2", done0, 1'b1);
        chk("busy_k2", busy0, 1'b0);
        chk("done1_k2", done1, 1'b1);
        chk("done2_k2", done2, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W0-1:0] a, b, ones;
        int pat;
        ones = '1;
        resetn = 1'b0; start = 1'b0; subtract = 1'b0; in_a = '0; in_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_result", result0, '0);
        chk("rst_pred", pred0, '0);
        resetn = 1'b1;
        @(negedge clk);

        // Directed corners: full carry chain, borrow, block boundary.
        issue(ones, {{(W0-1){1'b0}}, 1'b1}, 1'b0, 1'b0);
        chk("carry_chain_top_bit", result0, {1'b1, {W0{1'b0}}});
        issue({{(W0-3){1'b0}}, 3'd5}, {{(W0-3){1'b0}}, 3'd7}, 1'b1, 1'b0);
        chk("borrow_pred", pred0, 16'hFFFE);
        a = '0;
        for (int i = 0; i < 128; i++) a[i] = 1'b1;
        issue(a, {{(W0-1){1'b0}}, 1'b1}, 1'b0, 1'b0);

        // Start during busy must be ignored.
        issue(rnd_wide(), rnd_wide(), 1'b0, 1'b1);
        issue(rnd_wide(), rnd_wide(), 1'b1, 1'b1);

        // Reset in the middle of an operation aborts it silently.
        in_a = rnd_wide(); in_b = rnd_wide(); subtract = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        resetn = 1'b0;
        #1;
        chk("abort_busy", busy0, 1'b0);
        chk("abort_result", result0, '0);
        chk("abort_pred", pred0, '0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", done0, 1'b0);
        resetn = 1'b1;
        @(negedge clk);
        issue(rnd_wide(), rnd_wide(), 1'b1, 1'b0);

        // Random traffic, mostly back-to-back, with carry-heavy patterns mixed in.
        for (int n = 0; n < 10000; n++) begin
            pat = $urandom_range(0, 3);
            a = rnd_wide();
            case (pat)
                0: b = rnd_wide();
                1: begin a = ones; b = W0'($urandom_range(0, 3)); end
                2: b = a;
                default: b = ~a;
            endcase
            issue(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("gap_done_low", done0, 1'b0);
            end
        end

        repeat (5) @(negedge clk);
        chk("queues_drained", W0'(q0.size() + q1.size() + q2.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mpadder_cs_pipe.md
MPADDER_CS_PIPE -- requirements
Module: mpadder_cs_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 1026, operand width in bits.
REQ-002 SHALL have parameter BLK, default 128, carry-select block width; legal range PRED_W <= BLK < WIDTH.
REQ-003 SHALL have parameter PRED_W, default 16, width of the early-prediction output.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request that captures operands and mode.
REQ-007 SHALL have port subtract  input  1  mode select: 0 = a+b, 1 = a-b; sampled with start.
REQ-008 SHALL have port in_a  input  WIDTH  operand A, unsigned, sampled with start.
REQ-009 SHALL have port in_b  input  WIDTH  operand B, unsigned, sampled with start.
REQ-010 SHALL have port busy  output  1  high while an operation is in flight.
REQ-011 SHALL have port done  output  1  one-cycle pulse when result is valid.
REQ-012 SHALL have port result  output  WIDTH+1  registered sum or difference.
REQ-013 SHALL have port prediction  output  PRED_W  low PRED_W bits of the result, available one cycle early.

Function
REQ-014 SHALL compute result = (A op B) mod 2^(WIDTH+1), with both operands zero-extended to WIDTH+1 bits.
REQ-015 SHALL, for add, make result[WIDTH] the carry out; for subtract, result[WIDTH] = 1 iff A < B.
REQ-016 SHALL implement subtract as A + ~B + 1: B is inverted per bit and carry-in to block 0 is 1.
REQ-017 SHALL partition operands into NB = ceil(WIDTH/BLK) blocks; the top block covers the remainder bits plus the extension bit.
REQ-018 SHALL, in stage 1, compute block 0 with the true carry-in and blocks 1..NB-1 twice (carry-in 0 and 1), then register all sums and block carries.
REQ-019 SHALL, in stage 2, resolve the block carries by a ripple select over the registered carries, pick each block's sum, and register result.
REQ-020 SHALL use FSM states IDLE, STAGE1, STAGE2: IDLE->STAGE1 on start; STAGE1->STAGE2 unconditionally; STAGE2->IDLE unconditionally.
REQ-021 SHALL use latency 2: start sampled high at edge k -> prediction valid after edge k+1 -> result valid and done high after edge k+2.
REQ-022 SHALL drive busy high in STAGE1 and STAGE2 and low in IDLE; done is high only in the cycle after the STAGE2 edge.
REQ-023 SHALL ignore start while busy: operands and mode are not recaptured and the in-flight result is unaffected.
REQ-024 SHALL accept start in the same cycle done is high, giving back-to-back operations every 3 cycles.
REQ-025 SHALL hold result and prediction stable from valid until overwritten by the next operation's corresponding stage.
REQ-026 SHALL keep prediction equal to result[PRED_W-1:0] once done asserts.

Reset
REQ-027 SHALL, while resetn = 0, immediately force FSM = IDLE, busy = 0, done = 0, result = 0, prediction = 0 and all stage registers = 0.
REQ-028 SHALL abort an in-flight operation when reset is asserted mid-operation: no done pulse follows; the first start after release behaves normally.
REQ-029 SHALL ignore start in the first edge where resetn is low; resetn deasserting between edges takes effect at the next edge.

Verification
REQ-030 Add carry chain: A = 2^1026-1, B = 1, subtract = 0 -> result = 2^1026 (only bit 1026 set), done at k+2.
REQ-031 Subtract borrow: A = 5, B = 7, subtract = 1 -> result = 2^1027-2 (bit 1026 = 1), prediction = 16'hFFFE at k+1.
REQ-032 Block-boundary select: A = 2^128-1, B = 1, add -> result = 2^128; repeat with BLK = 64, WIDTH = 200 -> result = 2^128.
REQ-033 Handshake: start pulsed again at k+1 with different operands -> ignored, result from k operands; start asserted in the done cycle -> next done 3 cycles later.
REQ-034 Reset mid-operation: resetn low at k+1 -> done never pulses, result = 0; a new start after release produces a correct result.
REQ-035 Random: 10^4 random A/B/mode for default and (WIDTH = 256, BLK = 32) -> result matches reference A±B mod 2^(WIDTH+1), busy/done timing per REQ-021.
